stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
Time-base writer for the stopwatch display path: a prescaler divides the 50 MHz system clock into 10 ms ticks, which drive a cascaded BCD counter MM:SS.cc (centiseconds, seconds, minutes).
A Moore FSM (IDLE/RUN/PAUSE/LAP) handles start/stop, clear and lap-freeze.
The six 4-bit digit outputs feed the segment-scan multiplexer directly: t_ms0/t_ms1 are the centisecond digits, t_s0/t_s1 the seconds, t_m0/t_m1 the minutes.

Parameters:
CLK_HZ, 50_000_000, system clock frequency
TICK_HZ, 100, count resolution in Hz (10 ms)
PRESCALE, CLK_HZ/TICK_HZ, derived prescaler terminal count; width = clog2(PRESCALE)

Ports:
clk  in  1  system clock; the block uses one clock
rst  in  1  reset, asynchronous and active-high
start_stop  in  1  single-cycle pulse: start or stop counting
clear  in  1  single-cycle pulse: zero time, return to IDLE
lap  in  1  single-cycle pulse: freeze or release the displayed time
t_ms0  out  4  centiseconds units, BCD 0-9
t_ms1  out  4  centiseconds tens, BCD 0-9
t_s0  out  4  seconds units, BCD 0-9
t_s1  out  4  seconds tens, BCD 0-5
t_m0  out  4  minutes units, BCD 0-9
t_m1  out  4  minutes tens, BCD 0-5
running  out  1  high in RUN or LAP
wrap  out  1  one-cycle pulse when 59:59.99 rolls over to 00:00.00

Behaviour:
- Reset (async, rst=1): state=IDLE; prescaler=0; live and frozen digit registers all 0; running=0; wrap=0. All outputs are registered.
- Prescaler:
  - Increments only in RUN or LAP, holds in PAUSE, is 0 in IDLE.
  - tick is asserted when prescaler==PRESCALE-1 in RUN/LAP; prescaler then returns to 0 on that edge.
- Live counter:
  - On a tick edge, cs0 increments. Each digit carries to the next at its max: cs0 9, cs1 9, s0 9, s1 5, m0 9, m1 5.
  - Everything is combinational carry within one edge, so the whole chain updates on the same edge.
  - Rollover at 59:59.99 → 00:00.00 pulses wrap for exactly one cycle (the cycle after the edge), and counting continues.
- Output selection: outputs show the frozen registers in LAP and the live registers in every other state.
- FSM transitions (one per edge):
  - IDLE: start_stop → RUN. Prescaler starts from 0, so the first tick comes PRESCALE cycles after the edge that samples start_stop.
  - RUN: start_stop → PAUSE; lap → LAP, capturing the live digits into the frozen registers on that edge.
  - PAUSE: start_stop → RUN, resuming with the prescaler residue retained; lap is ignored.
  - LAP: lap → RUN, display returns to live; start_stop → PAUSE, display returns to live. Counting continues throughout LAP.
  - Any state: clear → IDLE, with live digits, frozen digits and prescaler all zeroed.
- Priority for simultaneous pulses in the same cycle: clear > start_stop > lap.
- If a tick coincides with a lap-capture edge, the frozen value is the pre-increment value.
- If a tick coincides with start_stop in RUN, the increment still occurs.
- rst asserted mid-count returns to the reset state immediately, with no completion of the pending tick.
- Input pulses longer than one cycle are each acted on per cycle; debounce and edge detection are upstream.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11;
  - digit maximum constants (DIG_MAX_9=4'd9, DIG_MAX_5=4'd5);
  - BCD digit type.
- One sub-module, bcd_digit_counter, instantiated six times:
  - parameter MAX;
  - inputs clk, rst, clr, inc;
  - outputs q[3:0] and carry = inc && q==MAX.
- The top level holds the prescaler, FSM, frozen registers, output mux and wrap detect.

Test Plan (CLK_HZ=1000, TICK_HZ=100 → PRESCALE=10):
- Reset then start_stop pulse, run 10 cycles → t_ms0 goes 0→1 on exactly the 10th edge after the start edge; running=1.
- Run 1000 ticks → digits read 00:10.00 (t_s1=1, others 0); after 99 more ticks, 00:10.99; the next tick gives 00:11.00.
- start_stop after 3 ticks plus 4 cycles, wait 50 cycles, start_stop again → digits hold at .03 during PAUSE; the next increment comes 6 cycles after resume.
- lap at 00:00.05, run 20 more ticks → outputs hold 00:00.05; a second lap shows 00:00.25.
- Run 360000 ticks → after 59:59.99 the counter reaches 00:00.00 with wrap high for exactly one cycle.
- clear, start_stop and lap asserted together in RUN → IDLE, all digits 0, running=0. A separate test asserts rst mid-count and checks that outputs go to 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_pkg
// Brief  : Shared FSM state encoding, BCD digit type and digit step helpers.
// Rev    : 1.0
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t DIG_MAX_9  = 4'd9;
    localparam bcd_digit_t DIG_MAX_5  = 4'd5;
    localparam int         NUM_DIGITS = 6;

    // Value a digit takes on the next edge; clear dominates increment.
    function automatic bcd_digit_t bcd_next(input bcd_digit_t q,
                                            input logic       inc,
                                            input logic       clr,
                                            input bcd_digit_t max_val);
        bcd_digit_t nxt;
        if (clr) begin
            nxt = '0;
        end else if (inc) begin
            nxt = (q == max_val) ? '0 : q + 4'd1;
        end else begin
            nxt = q;
        end
        return nxt;
    endfunction

    // Digit order is cs0, cs1, s0, s1, m0, m1; the tens of seconds and minutes stop at 5.
    function automatic bcd_digit_t digit_max(input int idx);
        return ((idx == 3) || (idx == 5)) ? DIG_MAX_5 : DIG_MAX_9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit_counter
// Brief  : One BCD digit of the stopwatch with combinational carry-out.
// Rev    : 1.0
// ============================================================================
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_digit_t MAX = DIG_MAX_9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= bcd_next(q, inc, clr, MAX);
        end
    end

    assign carry = inc && (q == MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_time_counter
// Brief  : 10 ms prescaler, MM:SS.cc BCD chain, run/pause/lap FSM, display regs.
// Rev    : 1.0
// ============================================================================
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] t_ms0,
    output logic [3:0] t_ms1,
    output logic [3:0] t_s0,
    output logic [3:0] t_s1,
    output logic [3:0] t_m0,
    output logic [3:0] t_m1,
    output logic       running,
    output logic       wrap
);

    localparam int              PRESCALE = CLK_HZ / TICK_HZ;
    localparam int              c_PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_TERM   = c_PW'(PRESCALE - 1);

    sw_state_t             r_state;
    sw_state_t             w_state_nxt;
    logic [c_PW-1:0]       r_presc;
    logic                  w_counting;
    logic                  w_tick;
    logic                  w_capture;
    logic                  w_c0, w_c1, w_c2, w_c3, w_c4, w_c5;
    logic [NUM_DIGITS-1:0] w_inc;
    bcd_digit_t            w_live       [NUM_DIGITS];
    bcd_digit_t            w_live_nxt   [NUM_DIGITS];
    bcd_digit_t            w_frozen_nxt [NUM_DIGITS];
    bcd_digit_t            r_frozen     [NUM_DIGITS];
    bcd_digit_t            r_disp       [NUM_DIGITS];
    logic                  r_running;
    logic                  r_wrap;

    assign w_counting = (r_state == RUN) || (r_state == LAP);
    assign w_tick     = w_counting && (r_presc == c_TERM);

    // Ripple carry: every stage sees the increment within the same edge.
    bcd_digit_counter #(.MAX(DIG_MAX_9)) u_cs0 (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_tick), .q(w_live[0]), .carry(w_c0));
    bcd_digit_counter #(.MAX(DIG_MAX_9)) u_cs1 (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c0),   .q(w_live[1]), .carry(w_c1));
    bcd_digit_counter #(.MAX(DIG_MAX_9)) u_s0 (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c1),   .q(w_live[2]), .carry(w_c2));
    bcd_digit_counter #(.MAX(DIG_MAX_5)) u_s1 (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c2),   .q(w_live[3]), .carry(w_c3));
    bcd_digit_counter #(.MAX(DIG_MAX_9)) u_m0 (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c3),   .q(w_live[4]), .carry(w_c4));
    bcd_digit_counter #(.MAX(DIG_MAX_5)) u_m1 (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c4),   .q(w_live[5]), .carry(w_c5));

    assign w_inc = {w_c4, w_c3, w_c2, w_c1, w_c0, w_tick};

    // Priority clear > start_stop > lap.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else if (start_stop) begin
            case (r_state)
                IDLE, PAUSE: w_state_nxt = RUN;
                default:     w_state_nxt = PAUSE;
            endcase
        end else if (lap) begin
            case (r_state)
                RUN:     w_state_nxt = LAP;
                LAP:     w_state_nxt = RUN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Capture samples the live digits before any coincident tick lands.
    assign w_capture = !clear && !start_stop && lap && (r_state == RUN);

    // Next-edge digit values let the display registers track with no extra lag.
    always_comb begin
        w_live_nxt   = w_live;
        w_frozen_nxt = r_frozen;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_live_nxt[i] = bcd_next(w_live[i], w_inc[i], clear, digit_max(i));
            if (clear) begin
                w_frozen_nxt[i] = '0;
            end else if (w_capture) begin
                w_frozen_nxt[i] = w_live[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_frozen[i] <= '0;
                r_disp[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            // PAUSE keeps the residue so a resume finishes the interrupted 10 ms.
            if (clear || (r_state == IDLE) || w_tick) begin
                r_presc <= '0;
            end else if (w_counting) begin
                r_presc <= r_presc + c_PW'(1);
            end
            r_running <= (w_state_nxt == RUN) || (w_state_nxt == LAP);
            r_wrap    <= w_c5 && !clear;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_frozen[i] <= w_frozen_nxt[i];
                r_disp[i]   <= (w_state_nxt == LAP) ? w_frozen_nxt[i] : w_live_nxt[i];
            end
        end
    end

    assign t_ms0   = r_disp[0];
    assign t_ms1   = r_disp[1];
    assign t_s0    = r_disp[2];
    assign t_s1    = r_disp[3];
    assign t_m0    = r_disp[4];
    assign t_m1    = r_disp[5];
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_stopwatch_time_counter
// Brief  : Directed scoreboard bench for stopwatch_time_counter (PRESCALE=10).
// Rev    : 1.0
// ============================================================================
module tb_stopwatch_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] t_ms0, t_ms1, t_s0, t_s1, t_m0, t_m1;
    logic       running, wrap;

    stopwatch_time_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .t_ms0(t_ms0), .t_ms1(t_ms1), .t_s0(t_s0), .t_s1(t_s1),
        .t_m0(t_m0), .t_m1(t_m1), .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        logic [23:0] dig;
        logic        run;
        logic        wr;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        drain_e;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Digits packed MM:SS.cc as hex BCD, e.g. 24'h001099 is 00:10.99.
    function automatic logic [23:0] shown();
        return {t_m1, t_m0, t_s1, t_s0, t_ms1, t_ms0};
    endfunction

    task automatic check(input string name, input logic [23:0] dig, input logic run, input logic wr);
        n_checks++;
        if (shown() === dig && running === run && wrap === wr) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h running=%b wrap=%b, want %h running=%b wrap=%b",
                     name, shown(), running, wrap, dig, run, wr);
        end
    endtask

    task automatic expect_at(input string name, input int unsigned d,
                             input logic [23:0] dig, input logic run, input logic wr);
        exp_t e;
        e.at   = cyc + d;
        e.dig  = dig;
        e.run  = run;
        e.wr   = wr;
        e.name = name;
        sb.push_back(e);
    endtask

    // Called at a negedge; the pulse is sampled by the next posedge and the
    // task returns at the following negedge, so cyc then indexes that edge.
    task automatic pulse(input logic ss, input logic cl, input logic lp);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.at != cyc) begin
                n_checks++;
                $display("FAIL %s: checked at cycle %0d, want cycle %0d", mon_e.name, cyc, mon_e.at);
            end else begin
                check(mon_e.name, mon_e.dig, mon_e.run, mon_e.wr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        expect_at("reset_state", 1, 24'h000000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        expect_at("idle_after_reset", 3, 24'h000000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // First tick latency and long count
        pulse(1'b1, 1'b0, 1'b0);
        expect_at("run_flag",    1,     24'h000000, 1'b1, 1'b0);
        expect_at("pre_tick",    9,     24'h000000, 1'b1, 1'b0);
        expect_at("first_tick",  10,    24'h000001, 1'b1, 1'b0);
        expect_at("ten_sec",     10000, 24'h001000, 1'b1, 1'b0);
        expect_at("ten_sec_99",  10990, 24'h001099, 1'b1, 1'b0);
        expect_at("ten_sec_99b", 10999, 24'h001099, 1'b1, 1'b0);
        expect_at("eleven_sec",  11000, 24'h001100, 1'b1, 1'b0);
        repeat (11002) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        expect_at("clear_idle", 1, 24'h000000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Pause keeps prescaler residue: stop at tick3+4 cycles
        pulse(1'b1, 1'b0, 1'b0);
        repeat (33) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        expect_at("pause_hold",      1,  24'h000003, 1'b0, 1'b0);
        expect_at("pause_hold_late", 50, 24'h000003, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        expect_at("resume",      1, 24'h000003, 1'b1, 1'b0);
        expect_at("resume_5cyc", 5, 24'h000003, 1'b1, 1'b0);
        expect_at("resume_tick", 6, 24'h000004, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Lap freeze, release, capture on a tick edge, LAP->PAUSE, lap in PAUSE
        pulse(1'b1, 1'b0, 1'b0);
        repeat (52) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        expect_at("lap_freeze", 1,   24'h000005, 1'b1, 1'b0);
        expect_at("lap_hold",   199, 24'h000005, 1'b1, 1'b0);
        repeat (199) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        expect_at("lap_release",    1, 24'h000025, 1'b1, 1'b0);
        expect_at("live_after_lap", 7, 24'h000026, 1'b1, 1'b0);
        repeat (16) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        expect_at("lap_on_tick",      1,  24'h000026, 1'b1, 1'b0);
        expect_at("lap_on_tick_hold", 10, 24'h000026, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        expect_at("lap_to_pause", 1, 24'h000028, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        expect_at("pause_ignores_lap", 2, 24'h000028, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Stop+lap on a tick edge, then all three pulses together
        pulse(1'b1, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b1);
        expect_at("stop_on_tick", 1, 24'h000003, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        pulse(1'b1, 1'b1, 1'b1);
        expect_at("clear_priority", 1,  24'h000000, 1'b0, 1'b0);
        expect_at("idle_stays",     20, 24'h000000, 1'b0, 1'b0);
        repeat (22) @(negedge clk);

        // Rollover: preload 59:59.00 while idle, then run 100 ticks
        force dut.u_s0.q = 4'd9;
        force dut.u_s1.q = 4'd5;
        force dut.u_m0.q = 4'd9;
        force dut.u_m1.q = 4'd5;
        @(negedge clk);
        release dut.u_s0.q;
        release dut.u_s1.q;
        release dut.u_m0.q;
        release dut.u_m1.q;
        expect_at("preload", 1, 24'h595900, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        expect_at("pre_wrap",   999,  24'h595999, 1'b1, 1'b0);
        expect_at("wrap_pulse", 1000, 24'h000000, 1'b1, 1'b1);
        expect_at("wrap_end",   1001, 24'h000000, 1'b1, 1'b0);
        expect_at("post_wrap",  1010, 24'h000001, 1'b1, 1'b0);
        repeat (1012) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Asynchronous reset one edge before a pending tick
        pulse(1'b1, 1'b0, 1'b0);
        expect_at("pre_reset", 34, 24'h000003, 1'b1, 1'b0);
        repeat (38) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", 24'h000000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        expect_at("reset_no_tick", 3, 24'h000000, 1'b0, 1'b0);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            drain_e = sb.pop_front();
            n_checks++;
            $display("FAIL %s: got no check by cycle %0d, want check at cycle %0d", drain_e.name, cyc, drain_e.at);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
